// File: rtl/stream_matrix_pkg.sv
// Shared bank-state type and sizing constants for the ping-pong matrix store.
package stream_matrix_pkg;

    localparam int NUM_BANKS  = 2;
    localparam int SKID_DEPTH = 2;

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

    // A bank can take input elements only while it is empty or mid-fill.
    function automatic logic is_open(bank_state_t s);
        return (s == EMPTY) || (s == FILLING);
    endfunction

endpackage

// File: rtl/stream_matrix_pingpong_if.sv
// Input element stream and packed output stream of the ping-pong matrix store.
interface stream_matrix_pingpong_if #(
    parameter int X_W  = 8,
    parameter int PACK = 4
);
    logic [X_W-1:0]      in_tdata;
    logic                in_tlast;
    logic                in_tvalid;
    logic                in_tready;
    logic [X_W*PACK-1:0] out_tdata;
    logic                out_tlast;
    logic                out_tvalid;
    logic                out_tready;

    modport master (
        output in_tdata, in_tlast, in_tvalid, out_tready,
        input  in_tready, out_tdata, out_tlast, out_tvalid
    );

    modport slave (
        input  in_tdata, in_tlast, in_tvalid, out_tready,
        output in_tready, out_tdata, out_tlast, out_tvalid
    );
endinterface

// File: rtl/stream_pack.sv
// Packs X_W-bit elements LSB-first into PACK lanes; emits a word when the lanes
// fill or the matrix closes, with lanes above the last element left at zero.
module stream_pack #(
    parameter int X_W  = 8,
    parameter int PACK = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_vld_i,
    input  logic [X_W-1:0]            in_data_i,
    input  logic                      close_i,
    output logic                      wr_en_o,
    output logic [PACK-1:0][X_W-1:0]  wr_data_o
);
    localparam int LW = (PACK > 1) ? $clog2(PACK) : 1;

    logic [LW-1:0] lcnt_q;
    logic [LW-1:0] lcnt_d;
    logic          flush;

    assign flush   = in_vld_i && (close_i || (lcnt_q == LW'(PACK - 1)));
    assign wr_en_o = flush;
    assign lcnt_d  = flush ? '0 : lcnt_q + LW'(1);

    always_ff @(posedge clk) begin
        if (rst)           lcnt_q <= '0;
        else if (in_vld_i) lcnt_q <= lcnt_d;
    end

    // The incoming element bypasses its lane so the flushing word is complete.
    for (genvar l = 0; l < PACK; l++) begin : g_lane
        logic [X_W-1:0] lane_q;
        logic           sel;

        assign sel          = (lcnt_q == LW'(l));
        assign wr_data_o[l] = sel ? in_data_i : lane_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                lane_q <= '0;
            end else if (in_vld_i) begin
                if (flush)    lane_q <= '0;
                else if (sel) lane_q <= in_data_i;
            end
        end
    end
endmodule

// File: rtl/stream_matrix_pingpong.sv
// Ping-pong matrix store: one bank fills from the element stream while the
// other replays its packed words REPEAT times through a 2-entry skid buffer.
module stream_matrix_pingpong
    import stream_matrix_pkg::*;
#(
    parameter int X_W          = 8,
    parameter int PACK         = 4,
    parameter int MATRIXSIZE_W = 24,
    parameter int MEM_WORDS    = 1024,
    parameter int REPEAT_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    stream_matrix_pingpong_if.slave axis,
    input  logic [MATRIXSIZE_W-1:0] DEPTH,
    input  logic [REPEAT_W-1:0]     REPEAT,
    output logic                    err_len,
    output logic                    busy
);
    localparam int Y_W = X_W * PACK;
    localparam int AW  = $clog2(MEM_WORDS);

    typedef struct packed {
        logic [Y_W-1:0] data;
        logic           last;
        logic           fin;
    } rd_ent_t;

    bank_state_t bank_q [NUM_BANKS];
    bank_state_t bank_d [NUM_BANKS];
    logic [AW:0] len_q  [NUM_BANKS];
    logic [Y_W-1:0] mem [NUM_BANKS*MEM_WORDS];

    // write side
    logic                    wbank_q, rdy_en_q, err_q;
    logic [MATRIXSIZE_W-1:0] cnt_q, depth_q, depth_eff;
    logic [AW-1:0]           wword_q;
    logic                    in_rdy, wr_hs, first, hit, close;
    logic                    pk_wr_en;
    logic [PACK-1:0][X_W-1:0] pk_wr_data;

    // read side
    bank_state_t         st_r;
    logic                rbank_q, rd_done_q;
    logic [AW-1:0]       raddr_q, cur_addr;
    logic [REPEAT_W-1:0] pass_q, rep_q, cur_pass, cur_rep;
    logic                cur_last, cur_final, rd_act, rd_issue;
    logic [1:0]          occ;
    logic                rd_vld_q, rd_last_q, rd_fin_q;
    logic [Y_W-1:0]      rdata_q;
    rd_ent_t             rd_ent, out_q, skid_q;
    logic                out_v_q, skid_v_q, pop, drain_done;

    assign in_rdy    = rdy_en_q && is_open(bank_q[wbank_q]);
    assign wr_hs     = axis.in_tvalid && in_rdy;
    assign first     = (bank_q[wbank_q] == EMPTY);
    assign depth_eff = first ? DEPTH : depth_q;
    assign hit       = ((cnt_q + MATRIXSIZE_W'(1)) == depth_eff);
    assign close     = wr_hs && (axis.in_tlast || hit);

    stream_pack #(.X_W(X_W), .PACK(PACK)) u_pack (
        .clk       (clk),
        .rst       (rst),
        .in_vld_i  (wr_hs),
        .in_data_i (axis.in_tdata),
        .close_i   (close),
        .wr_en_o   (pk_wr_en),
        .wr_data_o (pk_wr_data)
    );

    always_ff @(posedge clk) begin
        if (pk_wr_en) mem[{wbank_q, wword_q}] <= pk_wr_data;
    end

    // A FULL bank is read straight away at pass 0, address 0 with fresh REPEAT.
    assign st_r      = bank_q[rbank_q];
    assign rd_act    = (st_r == FULL) || ((st_r == DRAINING) && !rd_done_q);
    assign cur_addr  = (st_r == FULL) ? '0 : raddr_q;
    assign cur_pass  = (st_r == FULL) ? '0 : pass_q;
    assign cur_rep   = (st_r != FULL) ? rep_q :
                       (REPEAT == '0) ? REPEAT_W'(1) : REPEAT;
    assign cur_last  = (({1'b0, cur_addr} + (AW+1)'(1)) == len_q[rbank_q]);
    assign cur_final = cur_last && ((cur_pass + REPEAT_W'(1)) == cur_rep);

    // Credit: words held after this edge plus the one in the memory stage.
    assign pop        = out_v_q && axis.out_tready;
    assign occ        = {1'b0, out_v_q} + {1'b0, skid_v_q} + {1'b0, rd_vld_q} - {1'b0, pop};
    assign rd_issue   = rd_act && (occ < 2'(SKID_DEPTH));
    assign drain_done = pop && out_q.fin;
    assign rd_ent     = '{data: rdata_q, last: rd_last_q, fin: rd_fin_q};

    always_ff @(posedge clk) begin
        if (rd_issue) rdata_q <= mem[{rbank_q, cur_addr}];
    end

    always_comb begin
        bank_d = bank_q;
        if (wr_hs)            bank_d[wbank_q] = close ? FULL : FILLING;
        if (st_r == FULL)     bank_d[rbank_q] = DRAINING;
        if (drain_done)       bank_d[rbank_q] = EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_q[b] <= EMPTY;
                len_q[b]  <= '0;
            end
            wbank_q   <= 1'b0;
            rbank_q   <= 1'b0;
            rdy_en_q  <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            depth_q   <= '0;
            wword_q   <= '0;
            rd_done_q <= 1'b0;
            raddr_q   <= '0;
            pass_q    <= '0;
            rep_q     <= '0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
            rd_fin_q  <= 1'b0;
            out_q     <= '0;
            skid_q    <= '0;
            out_v_q   <= 1'b0;
            skid_v_q  <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            bank_q   <= bank_d;

            if (wr_hs) begin
                if (first) depth_q <= DEPTH;
                if (close) begin
                    cnt_q          <= '0;
                    wword_q        <= '0;
                    len_q[wbank_q] <= {1'b0, wword_q} + (AW+1)'(1);
                    wbank_q        <= ~wbank_q;
                    if (axis.in_tlast != hit) err_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + MATRIXSIZE_W'(1);
                    if (pk_wr_en) wword_q <= wword_q + AW'(1);
                end
            end

            rd_vld_q <= rd_issue;
            if (rd_issue) begin
                rd_last_q <= cur_last;
                rd_fin_q  <= cur_final;
                raddr_q   <= cur_last ? '0 : cur_addr + AW'(1);
                pass_q    <= cur_last ? cur_pass + REPEAT_W'(1) : cur_pass;
                if (cur_final) rd_done_q <= 1'b1;
            end else if (st_r == FULL) begin
                raddr_q <= '0;
                pass_q  <= '0;
            end
            if (st_r == FULL) rep_q <= cur_rep;

            if (pop || !out_v_q) begin
                if (skid_v_q) begin
                    out_q    <= skid_q;
                    out_v_q  <= 1'b1;
                    skid_v_q <= rd_vld_q;
                    if (rd_vld_q) skid_q <= rd_ent;
                end else begin
                    out_v_q <= rd_vld_q;
                    if (rd_vld_q) out_q <= rd_ent;
                end
            end else if (rd_vld_q) begin
                skid_q   <= rd_ent;
                skid_v_q <= 1'b1;
            end

            if (drain_done) begin
                rbank_q   <= ~rbank_q;
                rd_done_q <= 1'b0;
            end
        end
    end

    assign axis.in_tready  = in_rdy;
    assign axis.out_tdata  = out_q.data;
    assign axis.out_tlast  = out_q.last;
    assign axis.out_tvalid = out_v_q;
    assign err_len         = err_q;

    always_comb begin
        busy = out_v_q;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_q[b] != EMPTY) busy = 1'b1;
        end
    end
endmodule

// File: doc/stream_matrix_pingpong.md
Name: stream_matrix_pingpong

Overview:
- Double-buffered (ping-pong) matrix stream store.
- Accepts a matrix as an X_W-bit element stream and packs PACK elements per memory word.
- Replays each stored matrix REPEAT times as a Y_W = PACK*X_W stream, while the next matrix fills the other bank.
- Sits between an upstream producer and an AIE/PL consumer that needs an operand re-streamed. Replaces threshold-based pointer chasing with explicit per-bank ownership.

Parameters:
- X_W, 8, element width in bits.
- PACK, 4, elements per output word; Y_W = X_W*PACK.
- MATRIXSIZE_W, 24, width of the DEPTH port.
- MEM_WORDS, 1024, packed words per bank; power of two.
- REPEAT_W, 8, width of the REPEAT port.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_tdata  in  X_W  signed element
- in_tlast  in  1  last element of matrix
- in_tvalid  in  1  AXIS valid
- in_tready  out  1  AXIS ready
- out_tdata  out  X_W*PACK  packed word; element 0 in LSBs
- out_tlast  out  1  last word of each replay pass
- out_tvalid  out  1  AXIS valid
- out_tready  in  1  AXIS ready
- DEPTH  in  MATRIXSIZE_W  elements per matrix, 1..MEM_WORDS*PACK
- REPEAT  in  REPEAT_W  replay passes; 0 treated as 1
- err_len  out  1  sticky: in_tlast disagreed with DEPTH
- busy  out  1  any bank not EMPTY, or output valid

Behaviour:
- Reset: all banks EMPTY, wbank=rbank=0, all counters 0. in_tready=0, out_tvalid=0, out_tlast=0, err_len=0, busy=0. Reset mid-operation drops all stored and in-flight data.
- Bank state per bank: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
- Write side:
  - in_tready=1 iff bank[wbank] is EMPTY or FILLING. The first cycle after reset, in_tready=0.
  - DEPTH is sampled on the first handshake of a matrix; that handshake moves the bank from EMPTY to FILLING.
  - Elements are packed LSB-first into a PACK-lane register. A memory write occurs when the lane count reaches PACK or the matrix closes; unused lanes are zero.
  - The matrix closes on the handshake that has in_tlast=1 or that delivers element DEPTH, whichever comes first. If these do not coincide, err_len is set.
  - On close: bank length (in words) is recorded, the bank becomes FULL and wbank toggles, all on the same edge. in_tready next cycle reflects the other bank.
- Read side:
  - When bank[rbank] is FULL, it goes to DRAINING on the next edge. REPEAT is sampled at that transition.
  - Memory read latency is 1 cycle. A 2-entry skid/output register keeps out_tdata and out_tvalid stable while out_tready=0.
  - Reads issue only when the skid buffer has space. There are no bubbles when out_tready is held high.
  - out_tlast=1 on the final word of every pass.
  - After the last word of the last pass handshakes: bank becomes EMPTY and rbank toggles on the same edge.
- Latency: a close on edge t gives first out_tvalid at edge t+2, given that bank was next in order.
- Simultaneous events:
  - Write-close on one bank and drain-done on the other in the same cycle are both applied.
  - Writing and reading the same bank is impossible by construction.
  - Both banks FULL means in_tready=0 until a drain completes.
- Wrap: word addresses run 0..len-1 per pass and restart at 0 for each repeat. Bank base address = bank*MEM_WORDS.
- Width: element counter is MATRIXSIZE_W bits; pass counter is REPEAT_W bits. len = ceil(elements/PACK).

Decomposition:
- Package stream_matrix_pkg holds:
  - bank_state_t enum: EMPTY, FILLING, FULL, DRAINING.
  - Constants: NUM_BANKS=2 and skid depth 2.
- Sub-module stream_pack: the X_W-to-PACK-lane packer with flush on close. Memory is an inferred simple dual-port array of 2*MEM_WORDS words.

Test Plan:
- DEPTH=8, PACK=4, REPEAT=1, elements 1..8 with tlast on 8 -> two words, 0x04030201 then 0x08070605, tlast on the second; first out_tvalid 2 cycles after the close; err_len=0.
- DEPTH=6, REPEAT=3, out_tready held high -> 6 words out (2 words per pass), tlast on words 2, 4 and 6; second word 0x00000605 (zero-padded); no bubbles between passes.
- Back-to-back matrices A and B, out_tready=0 -> after A and B close, in_tready=0. Release out_tready -> A drains fully, then B; in_tready goes high the cycle after A's final handshake.
- Random out_tready 30% with DEPTH=12 -> output sequence identical to the ideal model; data stable whenever valid&&!ready.
- tlast on element 5 with DEPTH=8 -> bank closes with 2 words (second word 0x00000005), err_len=1 and stays 1 until rst.
- rst asserted mid-drain -> next cycle out_tvalid=0, busy=0. A new matrix is accepted normally after reset.
